// File: rtl/relay_switch_sequencer_pkg.sv
// Shared definitions for the relay switch sequencer: state encoding, selection codes
// and the relay one-hot decode.
package relay_switch_sequencer_pkg;

    localparam int unsigned NUM_RELAYS = 3;
    localparam logic [1:0]  SEL_NONE   = 2'd3;

    // 4-bit state codes, same width as the main supervisory FSM
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_BREAK = 4'd1;
    localparam logic [3:0] ST_MAKE  = 4'd2;
    localparam logic [3:0] ST_CHECK = 4'd3;
    localparam logic [3:0] ST_FAULT = 4'd4;

    typedef enum logic [3:0] {
        StIdle  = ST_IDLE,
        StBreak = ST_BREAK,
        StMake  = ST_MAKE,
        StCheck = ST_CHECK,
        StFault = ST_FAULT
    } seq_state_e;

    function automatic logic [NUM_RELAYS-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_RELAYS-1:0] oh;
        case (sel)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/relay_dwell_timer.sv
// Loadable down-counter used for both the dead-time and settle-time dwells.
// expired is high whenever the count has reached zero.
module relay_dwell_timer
    import relay_switch_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/relay_switch_sequencer.sv
// Break-before-make sequencer for three source relays with dead and settle dwells.
// Optional contact feedback check enabled by defining RELAY_FB_CHECK_EN.
module relay_switch_sequencer
    import relay_switch_sequencer_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES   = 50000,
    parameter int unsigned SETTLE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [1:0]            req_sel,
    output logic                  req_ready,
    output logic [NUM_RELAYS-1:0] relay_en,
    output logic [1:0]            active_sel,
    output logic                  busy,
    output logic                  done,
    input  logic [NUM_RELAYS-1:0] relay_fb,
    output logic                  fault,
    input  logic                  fault_clr
);

    localparam int unsigned MAX_CYCLES =
        (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    // Switching off completes one cycle earlier, so its dwell is one count shorter
    localparam logic [CNT_W-1:0] OFF_LOAD    =
        CNT_W'((DEAD_CYCLES >= 2) ? DEAD_CYCLES - 2 : 0);

    seq_state_e            state_q, state_d;
    logic [NUM_RELAYS-1:0] relay_en_q, relay_en_d;
    logic [1:0]            active_q, active_d;
    logic [1:0]            target_q, target_d;
    logic                  done_q, done_d;
    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_expired;

    relay_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

`ifdef RELAY_FB_CHECK_EN
    logic fault_q, fault_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            relay_en_q <= '0;
            active_q   <= SEL_NONE;
            target_q   <= SEL_NONE;
            done_q     <= 1'b0;
`ifdef RELAY_FB_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            relay_en_q <= relay_en_d;
            active_q   <= active_d;
            target_q   <= target_d;
            done_q     <= done_d;
`ifdef RELAY_FB_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        relay_en_d = relay_en_q;
        active_d   = active_q;
        target_d   = target_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = DEAD_LOAD;
`ifdef RELAY_FB_CHECK_EN
        fault_d    = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_sel == active_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d   = req_sel;
                        relay_en_d = '0;
                        active_d   = SEL_NONE;
                        if (req_sel == SEL_NONE && DEAD_CYCLES == 1) begin
                            done_d = 1'b1;
                        end else begin
                            state_d  = StBreak;
                            tmr_load = 1'b1;
                            tmr_val  = (req_sel == SEL_NONE) ? OFF_LOAD : DEAD_LOAD;
                        end
                    end
                end
            end
            StBreak: begin
                if (tmr_expired) begin
                    if (target_q == SEL_NONE) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = StMake;
                        relay_en_d = sel_onehot(target_q);
                        tmr_load   = 1'b1;
                        tmr_val    = SETTLE_LOAD;
                    end
                end
            end
            StMake: begin
                if (tmr_expired) begin
`ifdef RELAY_FB_CHECK_EN
                    state_d  = StCheck;
`else
                    state_d  = StIdle;
                    active_d = target_q;
                    done_d   = 1'b1;
`endif
                end
            end
`ifdef RELAY_FB_CHECK_EN
            StCheck: begin
                if (relay_fb == relay_en_q) begin
                    state_d  = StIdle;
                    active_d = target_q;
                    done_d   = 1'b1;
                end else begin
                    state_d    = StFault;
                    relay_en_d = '0;
                    active_d   = SEL_NONE;
                    fault_d    = 1'b1;
                end
            end
            StFault: begin
                if (fault_clr) begin
                    state_d = StIdle;
                    fault_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d    = StIdle;
                relay_en_d = '0;
                active_d   = SEL_NONE;
            end
        endcase
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign relay_en   = relay_en_q;
    assign active_sel = active_q;
    assign done       = done_q;

`ifdef RELAY_FB_CHECK_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
    logic unused_fb;
    assign unused_fb = ^{relay_fb, fault_clr};
`endif

endmodule

// File: tb/tb_relay_switch_sequencer.sv
// Directed bench for relay_switch_sequencer with a done-event scoreboard and a
// per-cycle one-hot invariant monitor.
module tb_relay_switch_sequencer;

    localparam int DEAD   = 4;
    localparam int SETTLE = 8;
`ifdef RELAY_FB_CHECK_EN
    localparam int FB_EXTRA = 1;
`else
    localparam int FB_EXTRA = 0;
`endif
    localparam int SEL_DELAY = DEAD + SETTLE + 1 + FB_EXTRA;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic       req_ready;
    logic [2:0] relay_en;
    logic [1:0] active_sel;
    logic       busy;
    logic       done;
    logic [2:0] relay_fb;
    logic       fault;
    logic       fault_clr = 1'b0;
    logic       fb_good = 1'b1;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    assign relay_fb = fb_good ? relay_en : 3'b000;

    relay_switch_sequencer #(
        .DEAD_CYCLES   (DEAD),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .relay_en   (relay_en),
        .active_sel (active_sel),
        .busy       (busy),
        .done       (done),
        .relay_fb   (relay_fb),
        .fault      (fault),
        .fault_clr  (fault_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and break-before-make invariant, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            assert ($countones(relay_en) <= 1) else begin
                n_err++;
                $error("FAIL onehot: relay_en=%b at cycle %0d, required at most one bit",
                       relay_en, cyc);
            end
            if (done === 1'b1) begin
                n_vec++;
                assert (q.size() != 0) else begin
                    n_err++;
                    $error("FAIL spurious_done: done=1 at cycle %0d, required no done", cyc);
                end
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    n_vec++;
                    assert (cyc === e.cyc && active_sel === e.sel) else begin
                        n_err++;
                        $error("FAIL done_timing: done at cycle %0d active_sel=%0d, required cycle %0d active_sel=%0d",
                               cyc, active_sel, e.cyc, e.sel);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h required %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic send(input logic [1:0] sel, input int delay, input bit push);
        exp_t e;
        chk("ready_before_send", {7'd0, req_ready}, 8'd1);
        req_valid = 1'b1;
        req_sel   = sel;
        if (push) begin
            e.cyc = cyc + delay;
            e.sel = sel;
            q.push_back(e);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {7'd0, q.size() == 0}, 8'd1);
        q.delete();
        tick();
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        // Reset state
        chk("rst_relay_en", {5'd0, relay_en}, 8'h00);
        chk("rst_active", {6'd0, active_sel}, 8'd3);
        chk("rst_ready", {7'd0, req_ready}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_fault", {7'd0, fault}, 8'd0);

        // None -> relay 1
        send(2'd1, SEL_DELAY, 1'b1);
        chk("sel1_busy", {7'd0, busy}, 8'd1);
        for (int i = 0; i < DEAD; i++) begin
            chk("sel1_dead", {5'd0, relay_en}, 8'h00);
            tick();
        end
        chk("sel1_make", {5'd0, relay_en}, 8'h02);
        wait_idle("sel1_wait");
        chk("sel1_active", {6'd0, active_sel}, 8'd1);
        chk("sel1_idle", {7'd0, busy}, 8'd0);

        // Relay 1 -> relay 2 with exactly DEAD cycles of all-off
        send(2'd2, SEL_DELAY, 1'b1);
        for (int i = 0; i < DEAD; i++) begin
            chk("sel2_dead", {5'd0, relay_en}, 8'h00);
            tick();
        end
        chk("sel2_make", {5'd0, relay_en}, 8'h04);
        wait_idle("sel2_wait");
        chk("sel2_active", {6'd0, active_sel}, 8'd2);

        // Same selection: immediate done, no relay change
        send(2'd2, 1, 1'b1);
        chk("same_relay_en", {5'd0, relay_en}, 8'h04);
        chk("same_busy", {7'd0, busy}, 8'd0);
        wait_idle("same_wait");

        send(2'd0, SEL_DELAY, 1'b1);
        wait_idle("sel0_wait");
        chk("sel0_active", {6'd0, active_sel}, 8'd0);

        // All off, with ignored requests while busy
        send(2'd3, DEAD, 1'b1);
        chk("off_relay_en", {5'd0, relay_en}, 8'h00);
        chk("off_active_early", {6'd0, active_sel}, 8'd3);
        req_valid = 1'b1;
        req_sel   = 2'd1;
        tick();
        tick();
        req_valid = 1'b0;
        wait_idle("off_wait");
        repeat (20) tick();
        chk("off_active", {6'd0, active_sel}, 8'd3);
        chk("off_relay_en_end", {5'd0, relay_en}, 8'h00);

        // Reset during MAKE drops the command
        send(2'd0, 0, 1'b0);
        repeat (DEAD + 2) tick();
        chk("mk_relay_en", {5'd0, relay_en}, 8'h01);
        rst = 1'b1;
        tick();
        chk("mkrst_relay_en", {5'd0, relay_en}, 8'h00);
        chk("mkrst_active", {6'd0, active_sel}, 8'd3);
        chk("mkrst_ready", {7'd0, req_ready}, 8'd1);
        chk("mkrst_done", {7'd0, done}, 8'd0);
        rst = 1'b0;
        repeat (20) tick();
        chk("mkrst_idle", {7'd0, busy}, 8'd0);

`ifdef RELAY_FB_CHECK_EN
        // Stuck-off feedback faults, clear, then good feedback completes
        fb_good = 1'b0;
        send(2'd0, 0, 1'b0);
        repeat (DEAD + SETTLE) tick();
        chk("fb_check_relay_en", {5'd0, relay_en}, 8'h01);
        chk("fb_check_fault", {7'd0, fault}, 8'd0);
        tick();
        chk("fb_fault", {7'd0, fault}, 8'd1);
        chk("fb_fault_relay_en", {5'd0, relay_en}, 8'h00);
        chk("fb_fault_busy", {7'd0, busy}, 8'd1);
        chk("fb_fault_active", {6'd0, active_sel}, 8'd3);
        tick();
        chk("fb_fault_held", {7'd0, fault}, 8'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fb_clr_fault", {7'd0, fault}, 8'd0);
        chk("fb_clr_ready", {7'd0, req_ready}, 8'd1);
        fb_good = 1'b1;
        send(2'd0, SEL_DELAY, 1'b1);
        wait_idle("fb_good_wait");
        chk("fb_good_active", {6'd0, active_sel}, 8'd0);
`else
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("noffb_fault", {7'd0, fault}, 8'd0);
        chk("noffb_ready", {7'd0, req_ready}, 8'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
